// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants: widths, map sizes, argmax index codes
// and the unpool row-phase state type.
package cnn_pkg;

  localparam int DATA_W  = 16;
  localparam int IN_DIM  = 14;
  localparam int OUT_DIM = 2 * IN_DIM;

  localparam logic [1:0] IDX_TL = 2'd0;
  localparam logic [1:0] IDX_TR = 2'd1;
  localparam logic [1:0] IDX_BL = 2'd2;
  localparam logic [1:0] IDX_BR = 2'd3;

  typedef enum logic {
    ST_TOP = 1'b0,
    ST_BOT = 1'b1
  } unpool_st_e;

endpackage

// File: rtl/unpool_rowbuf.sv
// One pooled row of {value, argmax idx}: a single write port and an
// asynchronous read port. Storage is never reset.
module unpool_rowbuf #(
  parameter int W     = 18,
  parameter int DEPTH = 14,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/maxunpool.sv
// 2x2 max-unpooling: each pooled element is placed at its argmax slot of
// a 2x2 window in a raster-order OUT_DIM x OUT_DIM output stream.
module maxunpool
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IN_DIM = cnn_pkg::IN_DIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_row_end,
  output logic              out_last
);

  localparam int OW = 2 * IN_DIM;
  localparam int CW = $clog2(OW);
  localparam int AW = CW - 1;
  localparam int BW = DATA_W + 2;

  unpool_st_e        r_st;
  unpool_st_e        w_st_nxt;
  logic [CW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_row_end;
  logic              r_last;

  logic              w_slot;
  logic              w_need_in;
  logic              w_fire;
  logic              w_adv;
  logic              w_col_end;
  logic              w_frame_end;
  logic              w_hit;
  logic [BW-1:0]     w_rb_rd;
  logic [DATA_W-1:0] w_src_d;
  logic [1:0]        w_src_i;

  assign w_slot      = !r_out_valid || out_ready;
  assign w_need_in   = (r_st == ST_TOP) && !r_col[0];
  assign in_ready    = w_slot && w_need_in;
  assign w_fire      = in_valid && in_ready;
  // Without a fresh element at an even TOP column nothing is produced.
  assign w_adv       = w_slot && (!w_need_in || in_valid);
  assign w_col_end   = r_col == CW'(OW - 1);
  assign w_frame_end = w_col_end && (r_row == CW'(OW - 1));

  assign w_src_d = w_need_in ? in_data : w_rb_rd[BW-1:2];
  assign w_src_i = w_need_in ? in_idx  : w_rb_rd[1:0];
  assign w_hit   = w_src_i == {r_row[0], r_col[0]};

  unpool_rowbuf #(
    .W    (BW),
    .DEPTH(IN_DIM),
    .AW   (AW)
  ) u_rowbuf (
    .clk  (clk),
    .we   (w_fire),
    .waddr(r_col[CW-1:1]),
    .wdata({in_data, in_idx}),
    .raddr(r_col[CW-1:1]),
    .rdata(w_rb_rd)
  );

  always_comb begin
    w_st_nxt = r_st;
    if (w_adv && w_col_end) begin
      unique case (r_st)
        ST_TOP:  w_st_nxt = ST_BOT;
        ST_BOT:  w_st_nxt = ST_TOP;
        default: w_st_nxt = ST_TOP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_st <= ST_TOP;
    else     r_st <= w_st_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_adv) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_frame_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_row_end   <= 1'b0;
      r_last      <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_hit ? w_src_d : '0;
      r_row_end   <= w_col_end;
      r_last      <= w_frame_end;
    end else if (w_slot) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_row_end = r_row_end;
  assign out_last    = r_last;

endmodule

// File: tb/tb_maxunpool.sv
// Self-checking bench for maxunpool: directed scenarios with random data
// checked against an arithmetic unpooling reference.
module tb_maxunpool;
  import cnn_pkg::*;

  localparam int NE   = IN_DIM * IN_DIM;
  localparam int NP   = OUT_DIM * OUT_DIM;
  localparam int NSRC = 2 * NE;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [1:0]        in_idx = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_row_end;
  logic              out_last;

  maxunpool dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_idx     (in_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row_end(out_row_end),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int ptr, pix, nz, nrowend, nlast;
  logic [DATA_W-1:0] sd [NSRC];
  logic [1:0]        si [NSRC];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: random; 1: row 0 idx=TL data=k+1; 2: single BR max in element 0
  task automatic new_stream(input int mode);
    for (int k = 0; k < NSRC; k++) begin
      sd[k] = DATA_W'($urandom);
      si[k] = 2'($urandom_range(0, 3));
      if (mode == 1 && k < IN_DIM) begin
        si[k] = IDX_TL;
        sd[k] = DATA_W'(k + 1);
      end
      if (mode == 2 && k < NE) begin
        sd[k] = (k == 0) ? DATA_W'(16'h7FFF) : '0;
        if (k == 0) si[k] = IDX_BR;
      end
    end
    ptr = 0; pix = 0; nz = 0; nrowend = 0; nlast = 0;
  endtask

  task automatic step(input bit iv, input bit ordy);
    int f, q, r, c, k;
    logic [DATA_W-1:0] e;
    @(negedge clk);
    in_valid  = iv && (ptr < NSRC);
    in_data   = sd[(ptr < NSRC) ? ptr : 0];
    in_idx    = si[(ptr < NSRC) ? ptr : 0];
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      f = pix / NP;
      q = pix % NP;
      r = q / OUT_DIM;
      c = q % OUT_DIM;
      k = f * NE + (r / 2) * IN_DIM + c / 2;
      if (k < NSRC) begin
        e = (int'(si[k]) == (r % 2) * 2 + (c % 2)) ? sd[k] : '0;
        chk("pix_data", 32'(out_data), 32'(e));
        chk("pix_row_end", 32'(out_row_end), 32'(c == OUT_DIM - 1));
        chk("pix_last", 32'(out_last), 32'(q == NP - 1));
      end else begin
        chk("pix_beyond_stream", 32'(pix), 32'(2 * NP));
      end
      if (out_data != '0) nz++;
      if (out_row_end) nrowend++;
      if (out_last) nlast++;
      pix++;
    end
    if (in_valid && in_ready) ptr++;
  endtask

  task automatic run_to(input int target, input bit gap, input bit toggle,
                        input int budget);
    for (int n = 0; n < budget && pix < target; n++)
      step(gap ? ($urandom_range(0, 3) != 0) : 1'b1,
           toggle ? ($urandom_range(0, 2) != 0) : 1'b1);
    chk("run_to_budget", 32'(pix), 32'(target));
  endtask

  task automatic do_reset(input int mode);
    @(negedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    new_stream(mode);
  endtask

  initial begin
    int n;
    new_stream(1);
    #3;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_out_data", 32'(out_data), 32'd0);
    chk("init_row_end", 32'(out_row_end), 32'd0);
    chk("init_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init_in_ready", 32'(in_ready), 32'd1);

    // row 0 = 1,0,2,0,...; row 1 all zeros
    run_to(2 * OUT_DIM, 1'b0, 1'b0, 200);
    chk("row01_nonzero", 32'(nz), 32'(IN_DIM));
    run_to(NP, 1'b0, 1'b0, 2000);

    // lone max at element 0, BR slot
    do_reset(2);
    run_to(NP, 1'b1, 1'b0, 3000);
    chk("lone_nonzero", 32'(nz), 32'd1);

    // downstream stall while pixel (0,6) is presented
    do_reset(0);
    run_to(6, 1'b0, 1'b0, 100);
    for (int s = 0; s < 5; s++) begin
      step(1'b1, 1'b0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data),
          32'((si[3] == IDX_TL) ? sd[3] : '0));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_ptr", 32'(ptr), 32'd4);
    end
    run_to(NP, 1'b0, 1'b0, 2000);

    // two frames with random input gaps and output back-pressure
    do_reset(0);
    run_to(2 * NP, 1'b1, 1'b1, 20000);
    chk("rowend_count", 32'(nrowend), 32'(2 * OUT_DIM));
    chk("last_count", 32'(nlast), 32'd2);

    // reset mid-frame after 30 accepted elements
    do_reset(0);
    n = 0;
    while (ptr < 30 && n < 500) begin
      step(1'b1, 1'b1);
      n++;
    end
    chk("pre_rst_ptr", 32'(ptr), 32'd30);
    do_reset(0);
    run_to(2 * OUT_DIM, 1'b1, 1'b0, 400);

    // input idle across the whole BOT row
    do_reset(0);
    n = 0;
    while (ptr < IN_DIM && n < 200) begin
      step(1'b1, 1'b1);
      n++;
    end
    for (int s = 0; s < 80; s++) begin
      n = pix;
      step(1'b0, 1'b1);
      if (n < 2 * OUT_DIM - 1)
        chk("bot_in_ready", 32'(in_ready), 32'd0);
    end
    chk("bot_pix", 32'(pix), 32'(2 * OUT_DIM));
    chk("bot_ptr", 32'(ptr), 32'(IN_DIM));
    chk("bot_drained", 32'(out_valid), 32'd0);
    chk("top_in_ready", 32'(in_ready), 32'd1);
    run_to(NP, 1'b1, 1'b1, 6000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
